uart_test_gen: RTL and testbench



---
 rtl/uart_test_pkg.sv | 40 ++++
 rtl/uart_echo_fifo.sv | 73 +++++++
 rtl/uart_test_gen.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_test_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_test_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_test_pkg
// Description : Shared definitions for the UART traffic generator: mode bit
//               positions, ASCII bytes of the status message, FSM state
//               encoding and a nibble-to-ASCII-hex helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_test_pkg;

    // Bit positions inside the 2-bit mode input
    localparam int c_mode_msg  = 0;
    localparam int c_mode_echo = 1;

    // Fixed bytes of the status message "CNT:xxxx\r\n"
    localparam logic [7:0] c_ascii_c     = 8'h43;
    localparam logic [7:0] c_ascii_n     = 8'h4E;
    localparam logic [7:0] c_ascii_t     = 8'h54;
    localparam logic [7:0] c_ascii_colon = 8'h3A;
    localparam logic [7:0] c_ascii_cr    = 8'h0D;
    localparam logic [7:0] c_ascii_lf    = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MSG_SEND  = 3'd1,
        S_MSG_WAIT  = 3'd2,
        S_ECHO_SEND = 3'd3,
        S_ECHO_WAIT = 3'd4
    } state_t;

    // 0-9 -> '0'-'9', 10-15 -> 'A'-'F'
    function automatic logic [7:0] nibble_to_hex(input logic [3:0] i_nib);
        if (i_nib < 4'd10) begin
            return 8'h30 + {4'h0, i_nib};
        end
        return 8'h37 + {4'h0, i_nib};
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_echo_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_echo_fifo
// Description : Synchronous first-word-fall-through byte FIFO used to hold
//               received bytes until they are echoed.
//   clk, rst   : clock, synchronous active-high reset
//   i_flush    : empties the FIFO (pointers cleared)
//   i_push     : write i_wdata (ignored when full, even with a same-cycle pop)
//   i_pop      : discard the head entry (ignored when empty)
//   o_rdata    : head entry, valid while o_empty=0
//   o_full     : no free entry
//   o_empty    : no stored entry
// Revision    : 1.0 - initial release
// ============================================================================
module uart_echo_fifo #(
    parameter int ECHO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_flush,
    input  logic       i_push,
    input  logic [7:0] i_wdata,
    input  logic       i_pop,
    output logic [7:0] o_rdata,
    output logic       o_full,
    output logic       o_empty
);

    localparam int c_aw = $clog2(ECHO_DEPTH);

    logic [7:0]    r_mem [ECHO_DEPTH];
    // One extra pointer bit distinguishes full from empty
    logic [c_aw:0] r_wptr;
    logic [c_aw:0] r_rptr;
    logic          w_full;
    logic          w_empty;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                       (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);
    // Push is qualified by the current full flag, so a same-cycle pop on a
    // full FIFO does not make room for it.
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !w_empty;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[c_aw-1:0]] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rptr[c_aw-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule
`default_nettype wire

// File: rtl/uart_test_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_test_gen
// Description : UART traffic source. Periodically sends "CNT:<hex count>\r\n"
//               and/or echoes received bytes through the transmit handshake.
//   clk, rst          : clock, synchronous active-high reset
//   i_mode[1:0]       : bit0 periodic message enable, bit1 echo enable
//   i_tx_busy         : UART transmitter busy
//   o_tx_en/o_tx_data : one-cycle transmit strobe and its byte
//   i_rx_data/i_rx_done : received byte and its one-cycle strobe
//   o_echo_overflow   : sticky, an echo byte was dropped on a full FIFO
//   o_msg_count       : number of completed status messages
// Revision    : 1.0 - initial release
// ============================================================================
module uart_test_gen
    import uart_test_pkg::*;
#(
    parameter int SYS_CLK_FRP = 50_000_000,
    parameter int INTERVAL_MS = 1000,
    parameter int ECHO_DEPTH  = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       i_mode,
    input  logic             i_tx_busy,
    output logic             o_tx_en,
    output logic [7:0]       o_tx_data,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_done,
    output logic             o_echo_overflow,
    output logic [CNT_W-1:0] o_msg_count
);

    localparam int c_tick_cycles = SYS_CLK_FRP / 1000 * INTERVAL_MS;
    localparam int c_tick_w      = (c_tick_cycles > 1) ? $clog2(c_tick_cycles) : 1;
    localparam int c_digits      = CNT_W / 4;
    localparam int c_msg_len     = 6 + c_digits;
    localparam int c_idx_w       = $clog2(c_msg_len);

    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(c_tick_cycles - 1);
    localparam logic [c_idx_w-1:0]  c_idx_cr    = c_idx_w'(c_msg_len - 2);
    localparam logic [c_idx_w-1:0]  c_idx_lf    = c_idx_w'(c_msg_len - 1);
    // Digit at message index k shows nibble (c_digits+3-k) of the snapshot
    localparam logic [c_idx_w-1:0]  c_nib_base  = c_idx_w'(c_digits + 3);

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_guard;
    logic [c_tick_w-1:0]  r_tick_cnt;
    logic                 r_msg_req;
    logic [c_idx_w-1:0]   r_idx;
    logic [CNT_W-1:0]     r_snap;
    logic [CNT_W-1:0]     r_msg_count;
    logic                 r_tx_en;
    logic [7:0]           r_tx_data;
    logic                 r_overflow;

    logic                 w_mode_msg;
    logic                 w_mode_echo;
    logic                 w_tick;
    logic                 w_start_msg;
    logic                 w_start_echo;
    logic                 w_load_msg;
    logic [c_idx_w-1:0]   w_next_idx;
    logic [c_idx_w-1:0]   w_digit_sel;
    logic [3:0]           w_nib;
    logic [7:0]           w_msg_byte;
    logic                 w_lf_fire;
    logic                 w_fifo_push;
    logic                 w_fifo_pop;
    logic [7:0]           w_fifo_rdata;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;

    assign w_mode_msg  = i_mode[c_mode_msg];
    assign w_mode_echo = i_mode[c_mode_echo];
    assign w_tick      = w_mode_msg && (r_tick_cnt == c_tick_last);
    assign w_fifo_push = i_rx_done && w_mode_echo;
    assign w_fifo_pop  = (r_state == S_ECHO_SEND);
    assign w_lf_fire   = (r_state == S_MSG_SEND) && (r_idx == c_idx_lf);

    uart_echo_fifo #(
        .ECHO_DEPTH (ECHO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (!w_mode_echo),
        .i_push  (w_fifo_push),
        .i_wdata (i_rx_data),
        .i_pop   (w_fifo_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Next-state logic. The WAIT states skip their first cycle so that the
    // transmitter has time to raise busy after the strobe.
    always_comb begin
        w_state_next = r_state;
        w_start_msg  = 1'b0;
        w_start_echo = 1'b0;
        w_load_msg   = 1'b0;
        w_next_idx   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (!i_tx_busy) begin
                    if (r_msg_req) begin
                        w_state_next = S_MSG_SEND;
                        w_start_msg  = 1'b1;
                        w_load_msg   = 1'b1;
                        w_next_idx   = '0;
                    end else if (!w_fifo_empty && w_mode_echo) begin
                        w_state_next = S_ECHO_SEND;
                        w_start_echo = 1'b1;
                    end
                end
            end
            S_MSG_SEND:  w_state_next = S_MSG_WAIT;
            S_MSG_WAIT: begin
                if (!r_guard && !i_tx_busy) begin
                    if (r_idx == c_idx_lf) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_MSG_SEND;
                        w_load_msg   = 1'b1;
                        w_next_idx   = r_idx + 1'b1;
                    end
                end
            end
            S_ECHO_SEND: w_state_next = S_ECHO_WAIT;
            S_ECHO_WAIT: begin
                if (!r_guard && !i_tx_busy) begin
                    w_state_next = S_IDLE;
                end
            end
            default:     w_state_next = S_IDLE;
        endcase
    end

    // Message byte at index w_next_idx
    assign w_digit_sel = c_nib_base - w_next_idx;
    assign w_nib       = 4'(r_snap >> {w_digit_sel, 2'b00});

    always_comb begin
        w_msg_byte = nibble_to_hex(w_nib);
        if (w_next_idx == c_idx_w'(0)) begin
            w_msg_byte = c_ascii_c;
        end else if (w_next_idx == c_idx_w'(1)) begin
            w_msg_byte = c_ascii_n;
        end else if (w_next_idx == c_idx_w'(2)) begin
            w_msg_byte = c_ascii_t;
        end else if (w_next_idx == c_idx_w'(3)) begin
            w_msg_byte = c_ascii_colon;
        end else if (w_next_idx == c_idx_cr) begin
            w_msg_byte = c_ascii_cr;
        end else if (w_next_idx == c_idx_lf) begin
            w_msg_byte = c_ascii_lf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_guard     <= 1'b0;
            r_tick_cnt  <= '0;
            r_msg_req   <= 1'b0;
            r_idx       <= '0;
            r_snap      <= '0;
            r_msg_count <= '0;
            r_tx_en     <= 1'b0;
            r_tx_data   <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_guard <= (r_state == S_MSG_SEND) || (r_state == S_ECHO_SEND);

            if (!w_mode_msg || w_tick) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end

            // Starting a message consumes the request; a tick while a
            // request is still pending is lost.
            if (!w_mode_msg || w_start_msg) begin
                r_msg_req <= 1'b0;
            end else if (w_tick) begin
                r_msg_req <= 1'b1;
            end

            // Strobe and data are registered so they land in the SEND state
            r_tx_en <= w_load_msg || w_start_echo;
            if (w_load_msg) begin
                r_tx_data <= w_msg_byte;
                r_idx     <= w_next_idx;
            end else if (w_start_echo) begin
                r_tx_data <= w_fifo_rdata;
            end

            if (w_start_msg) begin
                r_snap <= r_msg_count;
            end
            if (w_lf_fire) begin
                r_msg_count <= r_msg_count + 1'b1;
            end

            if (w_fifo_push && w_fifo_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_tx_en         = r_tx_en;
    assign o_tx_data       = r_tx_data;
    assign o_echo_overflow = r_overflow;
    assign o_msg_count     = r_msg_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_test_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_test_gen
// Description : Scoreboard bench for uart_test_gen. Expected transmit bytes
//               are queued with the stimulus; a monitor pops one per tx_en.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_test_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        tx_busy;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        echo_overflow;
    logic [15:0] msg_count;

    logic [7:0]  exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          n_pop  = 0;
    int          base;
    logic        force_busy = 1'b0;
    int          busy_cnt = 0;

    always #5 clk = ~clk;

    uart_test_gen #(
        .SYS_CLK_FRP (100_000),
        .INTERVAL_MS (1),
        .ECHO_DEPTH  (4),
        .CNT_W       (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_mode          (mode),
        .i_tx_busy       (tx_busy),
        .o_tx_en         (tx_en),
        .o_tx_data       (tx_data),
        .i_rx_data       (rx_data),
        .i_rx_done       (rx_done),
        .o_echo_overflow (echo_overflow),
        .o_msg_count     (msg_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            exp_q.push_back(s[i]);
        end
    endtask

    task automatic push_msg(input string s);
        push_str(s);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Busy rises one cycle after each strobe and stays up for 10 cycles
    task automatic busy_model();
        forever begin
            @(negedge clk);
            if (tx_en === 1'b1) begin
                busy_cnt = 11;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            tx_busy = force_busy || (busy_cnt > 0 && busy_cnt <= 10);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (tx_en === 1'b1) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tx actual=%0h required=none", tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("tx_data", {24'h0, tx_data}, {24'h0, e});
                end
            end
        end
    endtask

    task automatic wait_pops(input int target, input int budget, input string name);
        int n = 0;
        while (n_pop < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, (n_pop >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_empty(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 32'd0);
        repeat (20) @(negedge clk);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        mode    = 2'b00;
        rx_data = 8'h00;
        rx_done = 1'b0;
        tx_busy = 1'b0;
        fork
            monitor();
            busy_model();
        join_none
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_tx_en", {31'h0, tx_en}, 32'd0);
        check("rst_tx_data", {24'h0, tx_data}, 32'd0);
        check("rst_overflow", {31'h0, echo_overflow}, 32'd0);
        check("rst_msg_count", {16'h0, msg_count}, 32'd0);

        // Periodic messages only
        push_msg("CNT:0000");
        push_msg("CNT:0001");
        mode = 2'b01;
        wait_pops(15, 400, "t1_second_msg_started");
        mode = 2'b00;
        wait_empty(300, "t1_drain");
        check("t1_msg_count", {16'h0, msg_count}, 32'd2);

        // Echo only
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h43);
        mode = 2'b10;
        @(negedge clk);
        rx_byte(8'h41);
        rx_byte(8'h42);
        rx_byte(8'h43);
        wait_empty(200, "t2_drain");
        check("t2_overflow", {31'h0, echo_overflow}, 32'd0);

        // Echo overflow while transmitter is held busy
        force_busy = 1'b1;
        repeat (2) @(negedge clk);
        base = n_pop;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h10 + 8'(i));
        for (int i = 0; i < 6; i++) rx_byte(8'h10 + 8'(i));
        repeat (3) @(negedge clk);
        check("t3_held_no_tx", n_pop, base);
        check("t3_overflow_set", {31'h0, echo_overflow}, 32'd1);
        force_busy = 1'b0;
        wait_empty(300, "t3_drain");
        check("t3_overflow_sticky", {31'h0, echo_overflow}, 32'd1);

        // Both modes: echo byte waits for the message, then loses to a tick
        base = n_pop;
        push_msg("CNT:0002");
        push_msg("CNT:0003");
        exp_q.push_back(8'h55);
        mode = 2'b11;
        wait_pops(base + 3, 300, "t4_msg_in_progress");
        rx_byte(8'h55);
        wait_pops(base + 15, 400, "t4_second_msg_started");
        mode = 2'b10;
        wait_empty(400, "t4_drain");
        check("t4_msg_count", {16'h0, msg_count}, 32'd4);
        check("t4_overflow_sticky", {31'h0, echo_overflow}, 32'd1);

        // Reset in the middle of a message
        mode = 2'b01;
        base = n_pop;
        push_str("CNT:");
        wait_pops(base + 4, 300, "t5_partial_msg");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_rst_tx_en", {31'h0, tx_en}, 32'd0);
        check("t5_rst_tx_data", {24'h0, tx_data}, 32'd0);
        check("t5_rst_overflow", {31'h0, echo_overflow}, 32'd0);
        check("t5_rst_msg_count", {16'h0, msg_count}, 32'd0);
        check("t5_no_stale_bytes", exp_q.size(), 32'd0);
        push_msg("CNT:0000");
        wait_pops(base + 9, 300, "t5_restart");
        mode = 2'b00;
        wait_empty(300, "t5_drain");
        check("t5_msg_count", {16'h0, msg_count}, 32'd1);

        // Counter wrap from all-ones
        @(negedge clk);
        force dut.r_msg_count = 16'hFFFF;
        @(negedge clk);
        release dut.r_msg_count;
        base = n_pop;
        push_msg("CNT:FFFF");
        mode = 2'b01;
        wait_pops(base + 5, 300, "t6_msg_started");
        mode = 2'b00;
        wait_empty(300, "t6_drain");
        check("t6_msg_count_wrap", {16'h0, msg_count}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
